// File: rtl/ex_stage_pkg.sv
// Shared types for the execute stage: ALU operation encodings, branch funct3
// constants, the EX/MEM slot layout and the branch condition helper.
package ex_stage_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_SGE  = 4'd10,
        ALU_SGEU = 4'd11
    } alu_op_t;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] store_data;
        logic [4:0]      rd;
        logic            reg_write;
    } exmem_t;

    // The decoder picks an ALU op whose outcome encodes the condition:
    // SUB for equality tests, SLT/SGE/SLTU/SGEU for the ordered ones.
    function automatic logic branch_cond(input logic [2:0] funct3,
                                         input logic       zero,
                                         input logic       lsb);
        logic taken;
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = zero;
            F3_BNE:  taken = !zero;
            F3_BLT,
            F3_BGE,
            F3_BLTU,
            F3_BGEU: taken = lsb;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX input bundle, EX/MEM output slot and redirect path of the execute stage.
interface ex_stage_if;
    import ex_stage_pkg::*;

    // ID/EX side: instruction is transferred on an edge where in_valid && in_ready && !flush.
    // EX/MEM side: the slot is transferred on an edge where out_valid && out_ready;
    // while out_valid && !out_ready every slot output holds steady.
    logic            in_valid;
    logic            in_ready;
    alu_op_t         alu_op;
    logic [2:0]      funct3;
    logic            is_branch;
    logic            is_jal;
    logic            is_jalr;
    logic            src_a_pc;
    logic            src_b_imm;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic            reg_write;
    logic            flush;

    logic            out_ready;
    logic            out_valid;
    logic [XLEN-1:0] out_result;
    logic [XLEN-1:0] out_store_data;
    logic [4:0]      out_rd;
    logic            out_reg_write;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output in_valid, alu_op, funct3, is_branch, is_jal, is_jalr,
               src_a_pc, src_b_imm, rs1_val, rs2_val, imm, pc, rd, reg_write,
               flush, out_ready,
        input  in_ready, out_valid, out_result, out_store_data, out_rd,
               out_reg_write, redirect_valid, redirect_pc
    );

    modport slave (
        input  in_valid, alu_op, funct3, is_branch, is_jal, is_jalr,
               src_a_pc, src_b_imm, rs1_val, rs2_val, imm, pc, rd, reg_write,
               flush, out_ready,
        output in_ready, out_valid, out_result, out_store_data, out_rd,
               out_reg_write, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/ex_stage_alu.sv
// Combinational RV32I ALU with set-if-greater-or-equal extensions for branch compares.
module ex_stage_alu
    import ex_stage_pkg::*;
(
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  alu_op_t         alu_op,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    logic [4:0] shamt;
    logic       lt_signed;
    logic       lt_unsigned;

    assign shamt       = b[4:0];
    assign lt_signed   = $signed(a) < $signed(b);
    assign lt_unsigned = a < b;

    always_comb begin
        result = a + b;
        case (alu_op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << shamt;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, lt_signed};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, lt_unsigned};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            ALU_SGE:  result = {{(XLEN-1){1'b0}}, !lt_signed};
            ALU_SGEU: result = {{(XLEN-1){1'b0}}, !lt_unsigned};
            default:  result = a + b;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand select, ALU, branch/jump resolution and the registered
// EX/MEM slot with valid/ready flow control, flush and a one-shot redirect.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    ex_stage_if.slave  bus
);

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;
    logic [XLEN-1:0] pc_plus_imm;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] link_addr;
    logic            is_jump;
    logic            taken;
    logic [XLEN-1:0] target;
    logic            capture;
    exmem_t          slot_d;

    exmem_t          slot_q;
    logic            valid_q;
    logic            redir_valid_q;
    logic [XLEN-1:0] redir_pc_q;

    assign op_a = bus.src_a_pc  ? bus.pc  : bus.rs1_val;
    assign op_b = bus.src_b_imm ? bus.imm : bus.rs2_val;

    ex_stage_alu u_alu (
        .a      (op_a),
        .b      (op_b),
        .alu_op (bus.alu_op),
        .result (alu_result),
        .zero   (alu_zero)
    );

    assign pc_plus_imm = bus.pc + bus.imm;
    assign jalr_sum    = bus.rs1_val + bus.imm;
    assign link_addr   = bus.pc + XLEN'(4);
    assign is_jump     = bus.is_jal || bus.is_jalr;

    always_comb begin
        taken  = 1'b0;
        target = pc_plus_imm;
        if (is_jump) begin
            taken = 1'b1;
        end else if (bus.is_branch) begin
            taken = branch_cond(bus.funct3, alu_zero, alu_result[0]);
        end
        // JALR clears the low bit of its target; branches and JAL are pc-relative.
        if (bus.is_jalr) begin
            target = {jalr_sum[XLEN-1:1], 1'b0};
        end
    end

    always_comb begin
        slot_d            = '0;
        slot_d.result     = is_jump ? link_addr : alu_result;
        slot_d.store_data = bus.rs2_val;
        slot_d.rd         = bus.rd;
        slot_d.reg_write  = bus.reg_write;
    end

    assign bus.in_ready = !valid_q || bus.out_ready;
    assign capture      = bus.in_valid && bus.in_ready && !bus.flush;

    // Flush beats both capture and hold. The redirect clears every cycle it is
    // not re-armed by a capture, so a stalled slot never repeats the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q       <= 1'b0;
            slot_q        <= '0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
        end else begin
            redir_valid_q <= 1'b0;
            if (bus.flush) begin
                valid_q <= 1'b0;
            end else if (capture) begin
                valid_q       <= 1'b1;
                slot_q        <= slot_d;
                redir_valid_q <= taken;
                redir_pc_q    <= target;
            end else if (bus.out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid      = valid_q;
    assign bus.out_result     = slot_q.result;
    assign bus.out_store_data = slot_q.store_data;
    assign bus.out_rd         = slot_q.rd;
    assign bus.out_reg_write  = slot_q.reg_write && valid_q;
    assign bus.redirect_valid = redir_valid_q;
    assign bus.redirect_pc    = redir_pc_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios plus a randomized stream,
// with a scoreboard that checks every slot accepted by the MEM side.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ex_stage_if bus();

    ex_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int fails  = 0;
    int pulses = 0;
    logic [69:0] exp_q[$];
    logic rnd_ready = 1'b0;
    int wc;

    function automatic logic [31:0] model_alu(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ext;
        ext = {{32{a[31]}}, a} >> b[4:0];
        case (op)
            ALU_SUB:  return a - b;
            ALU_SLL:  return a << b[4:0];
            ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_XOR:  return a ^ b;
            ALU_SRL:  return a >> b[4:0];
            ALU_SRA:  return ext[31:0];
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            ALU_SGE:  return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
            ALU_SGEU: return (a >= b) ? 32'd1 : 32'd0;
            default:  return a + b;
        endcase
    endfunction

    function automatic logic model_taken(input logic br, input logic jal, input logic jalr,
                                         input logic [2:0] f3, input logic [31:0] res);
        if (jal || jalr) return 1'b1;
        if (!br) return 1'b0;
        if (f3 == 3'b000) return res == 32'd0;
        if (f3 == 3'b001) return res != 32'd0;
        if (f3[2]) return res[0];
        return 1'b0;
    endfunction

    // Scoreboard: every accepted slot must match the oldest outstanding capture.
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (bus.out_reg_write && !bus.out_valid) begin
                fails++;
                $display("FAIL reg_write_gating got out_reg_write=1 with out_valid=0, required 0");
            end
            if (bus.redirect_valid) pulses++;
            if (bus.out_valid && bus.out_ready) begin
                logic [69:0] e;
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL slot_unexpected got rd=%0d res=%h with empty expected queue", bus.out_rd, bus.out_result);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.out_rd, bus.out_reg_write, bus.out_store_data, bus.out_result} !== e) begin
                        fails++;
                        $display("FAIL slot_data got rd=%0d rw=%0b sd=%h res=%h required rd=%0d rw=%0b sd=%h res=%h",
                                 bus.out_rd, bus.out_reg_write, bus.out_store_data, bus.out_result,
                                 e[69:65], e[64], e[63:32], e[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid  = 1'b0;
        bus.is_branch = 1'b0;
        bus.is_jal    = 1'b0;
        bus.is_jalr   = 1'b0;
        bus.reg_write = 1'b0;
    endtask

    // Drives one instruction and returns just after the edge that captured it.
    task automatic issue(input alu_op_t op, input logic [2:0] f3,
                         input logic br, input logic jal, input logic jalr,
                         input logic sa, input logic sb,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [31:0] imm, input logic [31:0] pc,
                         input logic [4:0] rd, input logic rw, output int n_cycles);
        logic [31:0] a, b, res;
        logic cap;
        a   = sa ? pc : rs1;
        b   = sb ? imm : rs2;
        res = (jal || jalr) ? pc + 32'd4 : model_alu(op, a, b);
        bus.alu_op = op;     bus.funct3 = f3;
        bus.is_branch = br;  bus.is_jal = jal;  bus.is_jalr = jalr;
        bus.src_a_pc = sa;   bus.src_b_imm = sb;
        bus.rs1_val = rs1;   bus.rs2_val = rs2;
        bus.imm = imm;       bus.pc = pc;
        bus.rd = rd;         bus.reg_write = rw;
        bus.in_valid = 1'b1;
        cap = 1'b0;
        n_cycles = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            cap = bus.in_ready && !bus.flush;
            step();
            n_cycles++;
            if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
            if (cap) break;
        end
        if (cap) begin
            exp_q.push_back({rd, rw, rs2, res});
        end else begin
            checks++;
            fails++;
            $display("FAIL issue_timeout got no capture in 64 cycles, required capture");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        bus.alu_op = ALU_ADD; bus.funct3 = 3'b000;
        bus.src_a_pc = 1'b0;  bus.src_b_imm = 1'b0;
        bus.rs1_val = '0; bus.rs2_val = '0; bus.imm = '0; bus.pc = '0; bus.rd = '0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.out_valid, bus.out_reg_write, bus.redirect_valid} !== 3'b000) begin
            fails++;
            $display("FAIL reset_flags got %b required 000", {bus.out_valid, bus.out_reg_write, bus.redirect_valid});
        end
        checks++;
        if ({bus.out_result, bus.out_store_data, bus.out_rd, bus.redirect_pc} !== '0) begin
            fails++;
            $display("FAIL reset_data got res=%h sd=%h rd=%0d rpc=%h required all 0",
                     bus.out_result, bus.out_store_data, bus.out_rd, bus.redirect_pc);
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready got %b required 1", bus.in_ready);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add_stall();
        bus.out_ready = 1'b0;
        issue(ALU_ADD, 3'b000, 0, 0, 0, 0, 1, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h0, 5'd5, 1'b1, wc);
        checks++;
        if ({bus.out_valid, bus.out_rd, bus.out_result} !== {1'b1, 5'd5, 32'h0}) begin
            fails++;
            $display("FAIL add_wrap got v=%b rd=%0d res=%h required v=1 rd=5 res=0", bus.out_valid, bus.out_rd, bus.out_result);
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({bus.out_valid, bus.in_ready, bus.out_rd, bus.out_result} !== {1'b1, 1'b0, 5'd5, 32'h0}) begin
                fails++;
                $display("FAIL add_stall got v=%b in_ready=%b rd=%0d res=%h required v=1 in_ready=0 rd=5 res=0",
                         bus.out_valid, bus.in_ready, bus.out_rd, bus.out_result);
            end
        end
        bus.out_ready = 1'b1;
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL add_drain got out_valid=%b required 0", bus.out_valid);
        end
    endtask

    task automatic test_sra();
        issue(ALU_SRA, 3'b000, 0, 0, 0, 0, 1, 32'h8000_0000, 32'h1234, 32'h24, 32'h0, 5'd6, 1'b1, wc);
        checks++;
        if (bus.out_result !== 32'hF800_0000) begin
            fails++;
            $display("FAIL sra_result got %h required f8000000", bus.out_result);
        end
        idle();
        step();
    endtask

    task automatic test_bge();
        bus.out_ready = 1'b0;
        pulses = 0;
        issue(ALU_SGE, 3'b101, 1, 0, 0, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFF8, 32'h100, 5'd0, 1'b0, wc);
        checks++;
        if ({bus.redirect_valid, bus.redirect_pc, bus.out_result} !== {1'b1, 32'hF8, 32'h1}) begin
            fails++;
            $display("FAIL bge_redirect got rv=%b rpc=%h res=%h required rv=1 rpc=f8 res=1",
                     bus.redirect_valid, bus.redirect_pc, bus.out_result);
        end
        idle();
        step();
        checks++;
        if ({bus.redirect_valid, bus.out_valid} !== 2'b01) begin
            fails++;
            $display("FAIL bge_stall_pulse got rv=%b v=%b required rv=0 v=1", bus.redirect_valid, bus.out_valid);
        end
        step();
        bus.out_ready = 1'b1;
        step();
        checks++;
        if (pulses !== 1) begin
            fails++;
            $display("FAIL bge_pulse_count got %0d required 1", pulses);
        end
    endtask

    task automatic test_jalr();
        issue(ALU_ADD, 3'b000, 0, 0, 1, 0, 1, 32'h2001, 32'hABCD, 32'h2, 32'h40, 5'd1, 1'b1, wc);
        checks++;
        if ({bus.redirect_valid, bus.redirect_pc, bus.out_result, bus.out_reg_write} !== {1'b1, 32'h2002, 32'h44, 1'b1}) begin
            fails++;
            $display("FAIL jalr got rv=%b rpc=%h res=%h rw=%b required rv=1 rpc=2002 res=44 rw=1",
                     bus.redirect_valid, bus.redirect_pc, bus.out_result, bus.out_reg_write);
        end
        idle();
        step();
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        issue(ALU_ADD, 3'b000, 0, 1, 0, 1, 1, 32'h0, 32'h7, 32'h20, 32'h200, 5'd3, 1'b1, wc);
        checks++;
        if ({bus.redirect_valid, bus.redirect_pc} !== {1'b1, 32'h220}) begin
            fails++;
            $display("FAIL jal_redirect got rv=%b rpc=%h required rv=1 rpc=220", bus.redirect_valid, bus.redirect_pc);
        end
        bus.is_jal = 1'b0;
        bus.rd = 5'd9;
        bus.in_valid = 1'b1;
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        idle();
        void'(exp_q.pop_front());
        checks++;
        if ({bus.out_valid, bus.redirect_valid, bus.out_reg_write} !== 3'b000) begin
            fails++;
            $display("FAIL flush_drop got v=%b rv=%b rw=%b required 000", bus.out_valid, bus.redirect_valid, bus.out_reg_write);
        end
        bus.out_ready = 1'b1;
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_no_capture got out_valid=%b required 0", bus.out_valid);
        end
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        issue(ALU_OR, 3'b000, 0, 1, 0, 1, 1, 32'h0, 32'h55, 32'h8, 32'h300, 5'd7, 1'b1, wc);
        idle();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.out_reg_write, bus.redirect_valid, bus.out_result,
             bus.out_store_data, bus.out_rd, bus.redirect_pc} !== '0) begin
            fails++;
            $display("FAIL async_reset got v=%b rw=%b rv=%b res=%h sd=%h rd=%0d rpc=%h required all 0",
                     bus.out_valid, bus.out_reg_write, bus.redirect_valid, bus.out_result,
                     bus.out_store_data, bus.out_rd, bus.redirect_pc);
        end
        #1 rst_n = 1'b1;
        exp_q.delete();
        bus.out_ready = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(ALU_ADD, 3'b000, 0, 0, 0, 0, 1, 32'(i * 16), 32'(i), 32'(i + 1), 32'h0,
                  5'(10 + i), 1'b1, wc);
            checks++;
            if ({bus.out_valid, bus.out_rd, bus.out_result} !== {1'b1, 5'(10 + i), 32'(i * 17 + 1)} || wc != 1) begin
                fails++;
                $display("FAIL b2b_%0d got v=%b rd=%0d res=%h cycles=%0d required v=1 rd=%0d res=%h cycles=1",
                         i, bus.out_valid, bus.out_rd, bus.out_result, wc, 10 + i, i * 17 + 1);
            end
        end
        idle();
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_end got out_valid=%b required 0", bus.out_valid);
        end
    endtask

    task automatic test_random();
        rnd_ready = 1'b1;
        for (int n = 0; n < 24; n++) begin
            alu_op_t op;
            logic [2:0] f3;
            logic br, jal, jalr, sa, sb, tk;
            logic [31:0] rs1, rs2, imm, pc, res, tgt;
            int cls;
            op  = alu_op_t'(4'($urandom_range(0, 15)));
            f3  = 3'($urandom_range(0, 7));
            cls = $urandom_range(0, 3);
            br = (cls == 1); jal = (cls == 2); jalr = (cls == 3);
            sa = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
            rs1 = $urandom(); rs2 = $urandom();
            if ($urandom_range(0, 3) == 0) rs2 = rs1;
            imm = 32'($signed(12'($urandom_range(0, 4095))));
            pc  = {$urandom_range(0, 65535), 2'b00};
            res = model_alu(op, sa ? pc : rs1, sb ? imm : rs2);
            tk  = model_taken(br, jal, jalr, f3, res);
            tgt = jalr ? ((rs1 + imm) & ~32'h1) : pc + imm;
            issue(op, f3, br, jal, jalr, sa, sb, rs1, rs2, imm, pc, 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), wc);
            checks++;
            if (bus.redirect_valid !== tk || (tk && bus.redirect_pc !== tgt)) begin
                fails++;
                $display("FAIL rand_redirect_%0d got rv=%b rpc=%h required rv=%b rpc=%h",
                         n, bus.redirect_valid, bus.redirect_pc, tk, tgt);
            end
        end
        idle();
        rnd_ready = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8 && exp_q.size() != 0; i++) step();
        step();
    endtask

    initial begin
        test_reset();
        test_add_stall();
        test_sra();
        test_bge();
        test_jalr();
        test_flush();
        test_async_reset();
        test_back_to_back();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain_queue got %0d outstanding required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the pipelined RV32I core. It sits directly downstream of the ALU decoder and consumes its `alu_op` together with the operands and control bits from the ID/EX boundary. It computes the ALU result, resolves branches and jumps, and holds everything in a registered EX/MEM output slot with valid/ready flow control, stall and flush.

## Interface
- `XLEN`, 32, datapath width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  ID/EX holds a valid instruction.
- `in_ready`  out  1  stage can accept this cycle.
- `alu_op`  in  `alu_op_t`  operation from the ALU decoder.
- `funct3`  in  3  branch condition select.
- `is_branch`, `is_jal`, `is_jalr`  in  1 each  control-flow class; at most one is set.
- `src_a_pc`  in  1  operand A = `pc` instead of `rs1_val`.
- `src_b_imm`  in  1  operand B = `imm` instead of `rs2_val`.
- `rs1_val`, `rs2_val`, `imm`, `pc`  in  XLEN each  operands; `imm` is already sign-extended.
- `rd`  in  5  destination register.
- `reg_write`  in  1  instruction writes `rd`.
- `flush`  in  1  kill the held and incoming instruction.
- `out_ready`  in  1  MEM stage accepts.
- `out_valid`  out  1  EX/MEM slot valid.
- `out_result`  out  XLEN  ALU result, or `pc+4` for JAL/JALR.
- `out_store_data`  out  XLEN  registered `rs2_val`.
- `out_rd`  out  5  registered `rd`.
- `out_reg_write`  out  1  registered `reg_write`, gated by valid.
- `redirect_valid`  out  1  one-cycle pulse: taken branch or jump.
- `redirect_pc`  out  XLEN  target PC, valid when `redirect_valid` is high.

## Operation
- **Operands.** A = `src_a_pc ? pc : rs1_val`. B = `src_b_imm ? imm : rs2_val`.
- **ALU.** The ALU is combinational and operates on XLEN bits.
  - ADD and SUB wrap modulo 2^XLEN.
  - SLL, SRL and SRA use `B[4:0]` as the shift amount.
  - SLT and SLTU return 1 if A<B, otherwise 0 (signed and unsigned respectively).
  - SGE and SGEU return 1 if A>=B, otherwise 0 (signed and unsigned respectively).
  - XOR, OR and AND are bitwise.
  - Any undefined encoding behaves as ADD.
- **Branch taken** (`is_branch`), selected by `funct3`:
  - 000: result==0.
  - 001: result!=0.
  - 100, 101, 110, 111: `result[0]`.
  - All other values: not taken.
- **Targets.**
  - Branch and JAL: `pc + imm`.
  - JALR: `(rs1_val + imm) & ~1`.
  - JAL and JALR are always taken, and their result is `pc + 4`.
- **Handshake.**
  - `in_ready = !out_valid || out_ready` (combinational).
  - The stage captures when `in_valid && in_ready && !flush`.
  - The output slot is held stable while `out_valid && !out_ready`.
  - If nothing is captured and the slot drains, `out_valid` clears.
- **Flush.**
  - `flush` takes priority over capture and over hold: the next cycle has `out_valid=0`, `redirect_valid=0`, and nothing is captured.
- **Redirect.**
  - `redirect_valid` and `redirect_pc` are registered at capture time.
  - The pulse lasts exactly one cycle per captured taken instruction and does not repeat while the slot is stalled.

## Timing
- **Latency.** One cycle from capture to `out_valid` and `redirect_valid`.
- **Throughput.** One instruction per cycle when `out_ready` stays high.
- **Reset values.**
  - `out_valid`, `out_reg_write` and `redirect_valid` reset to 0.
  - `out_result`, `out_store_data`, `out_rd` and `redirect_pc` reset to 0.
  - Reset asserted mid-stall discards the held instruction immediately, without waiting for a clock edge.
- **Simultaneous drain and capture.** With `out_valid=1`, `out_ready=1` and `in_valid=1`, the slot is replaced in the same edge and there is no bubble.
- **Simultaneous flush and stall.** `flush` while `out_valid && !out_ready` drops the held instruction.
- **Gating.** `out_reg_write` is only ever 1 when `out_valid` is 1. `redirect_pc` is don't-care while `redirect_valid` is 0.

## Structure
- **Shared `types` package.**
  - `alu_op_t` already lives here and is extended with SGE and SGEU where missing.
  - The funct3 branch encodings are added here as named constants.
- **Sub-module `alu`.** Purely combinational, with ports `a`, `b`, `alu_op` → `result`, `zero`.
- **`ex_stage` itself** owns operand selection, branch resolution, the EX/MEM register and the handshake.

## Test plan
- **ADD, then stall.** `alu_op`=ADD, `rs1_val`=0xFFFFFFFF, `imm`=1, `src_b_imm`=1, `rd`=5.
  - Next cycle: `out_result`=0, `out_rd`=5, `out_valid`=1.
  - Hold `out_ready`=0 for 3 cycles: outputs stay stable and `in_ready`=0.
- **SRA.** A=0x80000000, B=0x24.
  - Shift amount is 4, so `out_result`=0xF8000000.
- **BGE taken.** `funct3`=101 (SGE), A=-1, B=-2, `pc`=0x100, `imm`=-8.
  - `redirect_valid` pulses for one cycle with `redirect_pc`=0xF8.
  - With `out_ready`=0 for 2 cycles, there is no second pulse.
- **JALR.** `rs1_val`=0x2001, `imm`=2, `pc`=0x40.
  - `redirect_pc`=0x2002 and `out_result`=0x44.
- **Flush.**
  - `flush`=1 with `in_valid`=1 during a stalled valid slot: next cycle `out_valid`=0, `redirect_valid`=0, and the new instruction is not captured.
  - Separately: `rst_n` pulsed low between edges while `out_valid`=1 → all outputs are 0 immediately.
- **Back-to-back stream.** 4 instructions with `out_ready`=1 continuously.
  - 4 consecutive `out_valid` cycles in order, with no bubbles.
